cart_bus_master: RTL and testbench

Host-side master for the Game Boy cartridge edge connector, the bus the console CPU drives. It turns single-byte read/write requests from the system fabric into cartridge bus cycles. It drives A15..A0, n_RD, n_WR, n_CS, n_RST and PHI, drives D7..D0 on writes, samples D7..D0 on reads, and returns read data. It sits between the FPGA memory map and the physical cartridge slot, mirroring the pin set of the cartridge-side interface.

---
 rtl/cart_bus_master.sv | 185 ++++++++++++++++++
 tb/tb_cart_bus_master.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_bus_master.sv
// Host-side cartridge bus master: turns single-byte fabric requests into
// timed cartridge bus cycles (setup / strobe / hold) and runs a free-running
// PHI clock and the cartridge reset sequence.
module cart_bus_master #(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 1,
  parameter int RST_CYCLES    = 16,
  parameter int PHI_HALF      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic        req_we,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  input  logic        cart_rst_req,
  output logic [15:0] cart_a,
  output logic [7:0]  cart_d_out,
  output logic        cart_d_oe,
  input  logic [7:0]  cart_d_in,
  output logic        cart_n_rd,
  output logic        cart_n_wr,
  output logic        cart_n_cs,
  output logic        cart_n_rst,
  output logic        cart_phi
);

  // state   | meaning
  // RESET   | cartridge n_RST held low, counting RST_CYCLES
  // IDLE    | waiting for a request or a cartridge reset request
  // SETUP   | address (and write data) driven, strobe still high
  // STROBE  | n_RD or n_WR low, n_CS low for external RAM window
  // HOLD    | strobes released, address/data still held

  localparam int MAX_A = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_B = (HOLD_CYCLES > RST_CYCLES) ? HOLD_CYCLES : RST_CYCLES;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAXP  = (MAX_C > PHI_HALF) ? MAX_C : PHI_HALF;
  localparam int CW    = $clog2(MAXP) + 1;

  typedef enum logic [2:0] {
    S_RESET,
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          we_q;
  logic [15:0]   cart_a_q;
  logic [7:0]    cart_d_out_q;
  logic          cart_d_oe_q;
  logic          cart_n_rd_q;
  logic          cart_n_wr_q;
  logic          cart_n_cs_q;
  logic          cart_n_rst_q;
  logic          rsp_valid_q;
  logic [7:0]    rsp_rdata_q;
  logic [CW-1:0] phi_cnt_q;
  logic          cart_phi_q;

  // Ready is only offered from IDLE, and a pending cartridge reset wins.
  assign req_ready = (state_q == S_IDLE) && !cart_rst_req && !rst;

  assign cart_a     = cart_a_q;
  assign cart_d_out = cart_d_out_q;
  assign cart_d_oe  = cart_d_oe_q;
  assign cart_n_rd  = cart_n_rd_q;
  assign cart_n_wr  = cart_n_wr_q;
  assign cart_n_cs  = cart_n_cs_q;
  assign cart_n_rst = cart_n_rst_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign cart_phi   = cart_phi_q;

  // Bus-cycle FSM with registered pin outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RESET;
      cnt_q        <= CW'(RST_CYCLES);
      we_q         <= 1'b0;
      cart_a_q     <= 16'h0000;
      cart_d_out_q <= 8'h00;
      cart_d_oe_q  <= 1'b0;
      cart_n_rd_q  <= 1'b1;
      cart_n_wr_q  <= 1'b1;
      cart_n_cs_q  <= 1'b1;
      cart_n_rst_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 8'hFF;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_RESET: begin
          if (cnt_q == CW'(1)) begin
            state_q      <= S_IDLE;
            cart_n_rst_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_IDLE: begin
          if (cart_rst_req) begin
            state_q      <= S_RESET;
            cnt_q        <= CW'(RST_CYCLES);
            cart_n_rst_q <= 1'b0;
          end else if (req_valid) begin
            state_q  <= S_SETUP;
            cnt_q    <= CW'(SETUP_CYCLES);
            we_q     <= req_we;
            cart_a_q <= req_addr;
            if (req_we) begin
              cart_d_out_q <= req_wdata;
              cart_d_oe_q  <= 1'b1;
            end else begin
              cart_d_oe_q  <= 1'b0;
            end
          end
        end
        S_SETUP: begin
          if (cnt_q == CW'(1)) begin
            state_q <= S_STROBE;
            cnt_q   <= CW'(STROBE_CYCLES);
            if (we_q) begin
              cart_n_wr_q <= 1'b0;
            end else begin
              cart_n_rd_q <= 1'b0;
            end
            cart_n_cs_q <= (cart_a_q[15:13] != 3'b101);
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_STROBE: begin
          if (cnt_q == CW'(1)) begin
            state_q     <= S_HOLD;
            cnt_q       <= CW'(HOLD_CYCLES);
            cart_n_rd_q <= 1'b1;
            cart_n_wr_q <= 1'b1;
            cart_n_cs_q <= 1'b1;
            if (!we_q) begin
              rsp_rdata_q <= cart_d_in;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_HOLD: begin
          if (cnt_q == CW'(1)) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b1;
            cart_d_oe_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q      <= S_RESET;
          cnt_q        <= CW'(RST_CYCLES);
          cart_n_rst_q <= 1'b0;
        end
      endcase
    end
  end

  // Free-running PHI: toggles every PHI_HALF clocks, stopped only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      phi_cnt_q  <= CW'(PHI_HALF);
      cart_phi_q <= 1'b0;
    end else if (phi_cnt_q == CW'(1)) begin
      phi_cnt_q  <= CW'(PHI_HALF);
      cart_phi_q <= ~cart_phi_q;
    end else begin
      phi_cnt_q <= phi_cnt_q - CW'(1);
    end
  end

endmodule

// File: tb/tb_cart_bus_master.sv
// Directed bench for cart_bus_master with default timing parameters.
module tb_cart_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        req_we;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        cart_rst_req;
  logic [15:0] cart_a;
  logic [7:0]  cart_d_out;
  logic        cart_d_oe;
  logic [7:0]  cart_d_in;
  logic        cart_n_rd;
  logic        cart_n_wr;
  logic        cart_n_cs;
  logic        cart_n_rst;
  logic        cart_phi;

  int total = 0;
  int bad   = 0;

  localparam int N = 40;

  logic        s_rst   [N];
  logic        s_valid [N];
  logic        s_we    [N];
  logic        s_rreq  [N];
  logic [15:0] s_addr  [N];
  logic [7:0]  s_wd    [N];

  logic [15:0] t_a    [N];
  logic [7:0]  t_dout [N];
  logic [7:0]  t_rd   [N];
  logic [3:0]  t_pins [N];
  logic        t_nrst [N];
  logic        t_phi  [N];
  logic        t_rv   [N];
  logic        t_rdy  [N];

  cart_bus_master dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_we       (req_we),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .cart_rst_req (cart_rst_req),
    .cart_a       (cart_a),
    .cart_d_out   (cart_d_out),
    .cart_d_oe    (cart_d_oe),
    .cart_d_in    (cart_d_in),
    .cart_n_rd    (cart_n_rd),
    .cart_n_wr    (cart_n_wr),
    .cart_n_cs    (cart_n_cs),
    .cart_n_rst   (cart_n_rst),
    .cart_phi     (cart_phi)
  );

  always #5 clk = ~clk;

  task automatic clear_stim();
    for (int k = 0; k < N; k++) begin
      s_rst[k]   = 1'b0;
      s_valid[k] = 1'b0;
      s_we[k]    = 1'b0;
      s_rreq[k]  = 1'b0;
      s_addr[k]  = 16'h0000;
      s_wd[k]    = 8'h00;
    end
  endtask

  // Applies the per-cycle stimulus just after each rising edge and records
  // outputs mid-cycle; pins = {n_rd, n_wr, n_cs, d_oe}.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      rst          = s_rst[k];
      req_valid    = s_valid[k];
      req_we       = s_we[k];
      req_addr     = s_addr[k];
      req_wdata    = s_wd[k];
      cart_rst_req = s_rreq[k];
      @(negedge clk);
      t_a[k]    = cart_a;
      t_dout[k] = cart_d_out;
      t_rd[k]   = rsp_rdata;
      t_pins[k] = {cart_n_rd, cart_n_wr, cart_n_cs, cart_d_oe};
      t_nrst[k] = cart_n_rst;
      t_phi[k]  = cart_phi;
      t_rv[k]   = rsp_valid;
      t_rdy[k]  = req_ready;
      @(posedge clk);
      #1;
    end
    req_valid    = 1'b0;
    cart_rst_req = 1'b0;
  endtask

  task automatic test_reset();
    clear_stim();
    for (int k = 0; k < 3; k++) s_rst[k] = 1'b1;
    run(23);
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({t_a[k], t_dout[k], t_rd[k], t_pins[k], t_nrst[k], t_phi[k], t_rv[k], t_rdy[k]}
          !== {16'h0000, 8'h00, 8'hFF, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL reset_vals k=%0d a=%h dout=%h rd=%h pins=%b nrst=%b phi=%b rv=%b rdy=%b",
                 k, t_a[k], t_dout[k], t_rd[k], t_pins[k], t_nrst[k], t_phi[k], t_rv[k], t_rdy[k]);
      end
    end
    for (int k = 3; k < 23; k++) begin
      total++;
      if ({t_nrst[k], t_rdy[k]} !== {((k - 3) >= 16), ((k - 3) >= 16)}) begin
        bad++;
        $display("FAIL powerup_nrst_rdy cyc=%0d got=%b%b exp=%b%b", k - 3, t_nrst[k], t_rdy[k],
                 ((k - 3) >= 16), ((k - 3) >= 16));
      end
      total++;
      if (t_phi[k] !== (((k - 3) / 4) % 2 == 1)) begin
        bad++;
        $display("FAIL phi cyc=%0d got=%b exp=%b", k - 3, t_phi[k], (((k - 3) / 4) % 2 == 1));
      end
    end
  endtask

  task automatic test_read();
    clear_stim();
    cart_d_in = 8'h1B;
    s_valid[0] = 1'b1; s_addr[0] = 16'h0147; s_we[0] = 1'b0;
    run(10);
    total++;
    if (t_rdy[0] !== 1'b1) begin
      bad++; $display("FAIL read_accept got=%b exp=1", t_rdy[0]);
    end
    for (int k = 0; k < 10; k++) begin
      total++;
      if (t_pins[k] !== {!(k >= 3 && k <= 6), 1'b1, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL read_pins cyc=%0d got=%b exp=%b", k, t_pins[k], {!(k >= 3 && k <= 6), 3'b110});
      end
      total++;
      if ({t_rv[k], t_rd[k]} !== {(k == 8), ((k <= 6) ? 8'hFF : 8'h1B)}) begin
        bad++;
        $display("FAIL read_rsp cyc=%0d got rv=%b rd=%h", k, t_rv[k], t_rd[k]);
      end
      if (k >= 1) begin
        total++;
        if (t_a[k] !== 16'h0147) begin
          bad++; $display("FAIL read_addr cyc=%0d got=%h exp=0147", k, t_a[k]);
        end
      end
    end
  endtask

  task automatic test_write();
    clear_stim();
    cart_d_in = 8'hEE;
    s_valid[0] = 1'b1; s_addr[0] = 16'h2000; s_we[0] = 1'b1; s_wd[0] = 8'h05;
    run(10);
    for (int k = 0; k < 10; k++) begin
      total++;
      if (t_pins[k] !== {1'b1, !(k >= 3 && k <= 6), 1'b1, (k >= 1 && k <= 7)}) begin
        bad++;
        $display("FAIL write_pins cyc=%0d got=%b exp=%b", k, t_pins[k],
                 {1'b1, !(k >= 3 && k <= 6), 1'b1, (k >= 1 && k <= 7)});
      end
      total++;
      if ({t_rv[k], t_rd[k]} !== {(k == 8), 8'h1B}) begin
        bad++;
        $display("FAIL write_rsp cyc=%0d got rv=%b rd=%h exp rv=%b rd=1b", k, t_rv[k], t_rd[k], (k == 8));
      end
      if (k >= 1 && k <= 7) begin
        total++;
        if ({t_a[k], t_dout[k]} !== {16'h2000, 8'h05}) begin
          bad++; $display("FAIL write_bus cyc=%0d got a=%h d=%h exp a=2000 d=05", k, t_a[k], t_dout[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_stim();
    cart_d_in = 8'h5A;
    s_valid[0] = 1'b1; s_addr[0] = 16'hA000; s_we[0] = 1'b1; s_wd[0] = 8'h5A;
    s_valid[8] = 1'b1; s_addr[8] = 16'hA000; s_we[8] = 1'b0;
    run(18);
    total++;
    if ({t_rdy[0], t_rdy[8]} !== 2'b11) begin
      bad++; $display("FAIL b2b_accept got=%b%b exp=11", t_rdy[0], t_rdy[8]);
    end
    for (int k = 0; k < 18; k++) begin
      total++;
      if (t_pins[k] !== {!(k >= 11 && k <= 14), !(k >= 3 && k <= 6),
                         !((k >= 3 && k <= 6) || (k >= 11 && k <= 14)), (k >= 1 && k <= 7)}) begin
        bad++;
        $display("FAIL b2b_pins cyc=%0d got=%b", k, t_pins[k]);
      end
      total++;
      if ({t_rv[k], t_rd[k]} !== {(k == 8 || k == 16), ((k <= 14) ? 8'h1B : 8'h5A)}) begin
        bad++;
        $display("FAIL b2b_rsp cyc=%0d got rv=%b rd=%h", k, t_rv[k], t_rd[k]);
      end
    end
  endtask

  task automatic test_cart_rst_req();
    clear_stim();
    cart_d_in = 8'h77;
    s_valid[0] = 1'b1; s_addr[0] = 16'h4000;
    for (int k = 4; k < 20; k++) s_rreq[k] = 1'b1;
    for (int k = 8; k <= 25; k++) begin
      s_valid[k] = 1'b1; s_addr[k] = 16'h1234;
    end
    run(34);
    for (int k = 0; k < 34; k++) begin
      total++;
      if ({t_nrst[k], t_rdy[k], t_rv[k]} !== {!(k >= 9 && k <= 24), (k == 0 || k == 25 || k == 33),
                                             (k == 8 || k == 33)}) begin
        bad++;
        $display("FAIL rstreq_ctl cyc=%0d got nrst/rdy/rv=%b%b%b", k, t_nrst[k], t_rdy[k], t_rv[k]);
      end
      total++;
      if (t_pins[k][3] !== !((k >= 3 && k <= 6) || (k >= 28 && k <= 31))) begin
        bad++; $display("FAIL rstreq_nrd cyc=%0d got=%b", k, t_pins[k][3]);
      end
    end
    total++;
    if ({t_rd[8], t_a[24], t_a[26]} !== {8'h77, 16'h4000, 16'h1234}) begin
      bad++;
      $display("FAIL rstreq_data got rd=%h a24=%h a26=%h exp 77 4000 1234", t_rd[8], t_a[24], t_a[26]);
    end
  endtask

  task automatic test_rst_mid_read();
    clear_stim();
    cart_d_in = 8'h99;
    s_valid[0] = 1'b1; s_addr[0] = 16'h3FFF;
    s_rst[4] = 1'b1; s_rst[5] = 1'b1;
    run(24);
    for (int k = 0; k < 24; k++) begin
      total++;
      if (t_rv[k] !== 1'b0) begin
        bad++; $display("FAIL rstmid_rv cyc=%0d got=%b exp=0", k, t_rv[k]);
      end
      total++;
      if (t_pins[k] !== {!(k == 3 || k == 4), 3'b110}) begin
        bad++; $display("FAIL rstmid_pins cyc=%0d got=%b", k, t_pins[k]);
      end
      if (k >= 5) begin
        total++;
        if ({t_a[k], t_rd[k], t_nrst[k], t_rdy[k]} !== {16'h0000, 8'hFF, (k >= 22), (k >= 22)}) begin
          bad++;
          $display("FAIL rstmid_state cyc=%0d got a=%h rd=%h nrst=%b rdy=%b", k, t_a[k], t_rd[k],
                   t_nrst[k], t_rdy[k]);
        end
      end
    end
    total++;
    if (t_phi[5] !== 1'b0) begin
      bad++; $display("FAIL rstmid_phi got=%b exp=0", t_phi[5]);
    end
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_addr     = 16'h0000;
    req_we       = 1'b0;
    req_wdata    = 8'h00;
    cart_rst_req = 1'b0;
    cart_d_in    = 8'h00;
    @(posedge clk);
    #1;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_cart_rst_req();
    test_rst_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
